// File: rtl/syscall_unit.sv
`default_nettype none
// ============================================================================
// Module   : syscall_unit
// Brief    : Syscall service sequencer (halt / print / pause) with PC enable
//            and run statistics for the board display.
// Revision : 1.0 - initial release
// ============================================================================
module syscall_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned HALT_CODE  = 10,
    parameter int unsigned PRINT_CODE = 34,
    parameter int unsigned PAUSE_CODE = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IsSyscall,
    input  logic [WIDTH-1:0] V0,
    input  logic [WIDTH-1:0] A0,
    input  logic             Go,
    output logic             PcEn,
    output logic             Halted,
    output logic             Paused,
    output logic [WIDTH-1:0] LedData,
    output logic [WIDTH-1:0] SyscallCount,
    output logic [WIDTH-1:0] CycleCount
);

    localparam logic [WIDTH-1:0] C_HALT  = WIDTH'(HALT_CODE);
    localparam logic [WIDTH-1:0] C_PRINT = WIDTH'(PRINT_CODE);
    localparam logic [WIDTH-1:0] C_PAUSE = WIDTH'(PAUSE_CODE);
    localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSE  = 2'd1,
        ST_RESUME = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             go_q;
    logic [WIDTH-1:0] led_q, led_d;
    logic [WIDTH-1:0] sys_cnt_q;
    logic [WIDTH-1:0] cyc_cnt_q;
    logic             w_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            go_q      <= 1'b0;
            led_q     <= '0;
            sys_cnt_q <= '0;
            cyc_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= Go;
            led_q   <= led_d;
            if (w_acc)
                sys_cnt_q <= sys_cnt_q + C_ONE;
            // The halting syscall's own cycle still counts: the test is on the current state.
            if (state_q != ST_HALT)
                cyc_cnt_q <= cyc_cnt_q + C_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        PcEn    = 1'b0;
        w_acc   = 1'b0;
        case (state_q)
            ST_RUN: begin
                PcEn = 1'b1;
                if (IsSyscall) begin
                    w_acc = 1'b1;
                    if (V0 == C_HALT) begin
                        PcEn    = 1'b0;
                        state_d = ST_HALT;
                    end else if (V0 == C_PAUSE) begin
                        PcEn    = 1'b0;
                        state_d = ST_PAUSE;
                    end else if (V0 == C_PRINT) begin
                        led_d = A0;
                    end
                end
            end
            ST_PAUSE: begin
                if (Go && !go_q)
                    state_d = ST_RESUME;
            end
            // One-cycle step past the pausing syscall; it is not re-accepted here.
            ST_RESUME: begin
                PcEn    = 1'b1;
                state_d = ST_RUN;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign Halted       = (state_q == ST_HALT);
    assign Paused       = (state_q == ST_PAUSE);
    assign LedData      = led_q;
    assign SyscallCount = sys_cnt_q;
    assign CycleCount   = cyc_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_syscall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_syscall_unit
// Brief    : Directed self-checking bench for syscall_unit (32-bit instance
//            plus a 4-bit instance for counter wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_syscall_unit;

    logic        clk;
    logic        rst;
    logic        IsSyscall;
    logic [31:0] V0, A0;
    logic        Go;
    logic        PcEn, Halted, Paused;
    logic [31:0] LedData, SyscallCount, CycleCount;

    logic        rst4;
    logic        PcEn4, Halted4, Paused4;
    logic [3:0]  LedData4, SyscallCount4, CycleCount4;

    int n_checks = 0;
    int n_errors = 0;

    syscall_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .IsSyscall(IsSyscall), .V0(V0), .A0(A0), .Go(Go),
        .PcEn(PcEn), .Halted(Halted), .Paused(Paused), .LedData(LedData),
        .SyscallCount(SyscallCount), .CycleCount(CycleCount)
    );

    syscall_unit #(.WIDTH(4), .HALT_CODE(10), .PRINT_CODE(3), .PAUSE_CODE(5)) u_dut4 (
        .clk(clk), .rst(rst4), .IsSyscall(1'b0), .V0(4'd0), .A0(4'd0), .Go(1'b0),
        .PcEn(PcEn4), .Halted(Halted4), .Paused(Paused4), .LedData(LedData4),
        .SyscallCount(SyscallCount4), .CycleCount(CycleCount4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        IsSyscall = 1'b0; V0 = '0; A0 = '0; Go = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_pcen",   {31'd0, PcEn},   32'd1);
        check("rst_halted", {31'd0, Halted}, 32'd0);
        check("rst_paused", {31'd0, Paused}, 32'd0);
        check("rst_led",    LedData,         32'd0);
        check("rst_cyc",    CycleCount,      32'd0);

        // Idle run
        for (int i = 0; i < 5; i++) begin
            check("idle_pcen", {31'd0, PcEn}, 32'd1);
            tick();
        end
        check("idle_cyc", CycleCount,   32'd5);
        check("idle_sys", SyscallCount, 32'd0);
        check("idle_led", LedData,      32'd0);

        // PRINT
        IsSyscall = 1'b1; V0 = 32'd34; A0 = 32'hDEADBEEF;
        #1 check("print_pcen", {31'd0, PcEn}, 32'd1);
        tick();
        IsSyscall = 1'b0;
        #1;
        check("print_led",  LedData,         32'hDEADBEEF);
        check("print_sys",  SyscallCount,    32'd1);
        check("print_cyc",  CycleCount,      32'd6);
        check("print_run",  {31'd0, PcEn},   32'd1);

        // Unknown code whose low bits match HALT: full-width compare makes it a no-op
        IsSyscall = 1'b1; V0 = 32'h0001_000A; A0 = 32'h1111_1111;
        #1 check("other_pcen", {31'd0, PcEn}, 32'd1);
        tick();
        check("other_halt", {31'd0, Halted}, 32'd0);
        check("other_sys",  SyscallCount,    32'd2);
        check("other_led",  LedData,         32'hDEADBEEF);

        // HALT, held
        V0 = 32'd10;
        #1 check("halt_pcen0", {31'd0, PcEn}, 32'd0);
        tick();
        check("halt_flag", {31'd0, Halted}, 32'd1);
        check("halt_cyc",  CycleCount,      32'd8);
        check("halt_sys",  SyscallCount,    32'd3);
        Go = 1'b1; tick(); Go = 1'b0; tick(); tick();
        check("halt_stay", {31'd0, Halted}, 32'd1);
        check("halt_pcen", {31'd0, PcEn},   32'd0);
        check("halt_cycf", CycleCount,      32'd8);
        check("halt_sysf", SyscallCount,    32'd3);
        rst = 1'b1; tick(); rst = 1'b0; IsSyscall = 1'b0;
        #1;
        check("hrst_halt", {31'd0, Halted}, 32'd0);
        check("hrst_cyc",  CycleCount,      32'd0);
        check("hrst_sys",  SyscallCount,    32'd0);
        check("hrst_led",  LedData,         32'd0);

        // PAUSE entered with Go already held
        Go = 1'b1; tick();
        IsSyscall = 1'b1; V0 = 32'd50;
        #1 check("pause_pcen0", {31'd0, PcEn}, 32'd0);
        tick();
        check("pause_flag", {31'd0, Paused}, 32'd1);
        check("pause_sys",  SyscallCount,    32'd1);
        repeat (3) tick();
        check("pause_hold", {31'd0, Paused}, 32'd1);
        check("pause_pcen", {31'd0, PcEn},   32'd0);
        Go = 1'b0; tick();
        Go = 1'b1;
        #1 check("pause_edge_pcen", {31'd0, PcEn}, 32'd0);
        tick();
        check("resume_pcen",   {31'd0, PcEn},   32'd1);
        check("resume_paused", {31'd0, Paused}, 32'd0);
        IsSyscall = 1'b0; Go = 1'b0;
        tick();
        check("resume_sys",  SyscallCount,    32'd1);
        check("resume_cyc",  CycleCount,      32'd8);
        check("resume_run",  {31'd0, PcEn},   32'd1);
        check("resume_halt", {31'd0, Halted}, 32'd0);

        // Reset while paused with LedData nonzero
        IsSyscall = 1'b1; V0 = 32'd34; A0 = 32'h0000_1234;
        tick();
        check("p2_led", LedData, 32'h0000_1234);
        V0 = 32'd50;
        tick();
        IsSyscall = 1'b0;
        check("p2_paused", {31'd0, Paused}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        check("prst_paused", {31'd0, Paused}, 32'd0);
        check("prst_pcen",   {31'd0, PcEn},   32'd1);
        check("prst_led",    LedData,         32'd0);

        // 4-bit counter wrap
        rst4 = 1'b0;
        repeat (15) tick();
        check("wrap_pre",  {28'd0, CycleCount4},    32'd15);
        tick();
        check("wrap_zero", {28'd0, CycleCount4},    32'd0);
        check("wrap_sys",  {28'd0, SyscallCount4},  32'd0);
        check("wrap_pcen", {31'd0, PcEn4},          32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Sequential consumer of the syscall flag produced by the control unit's ALU decoder (asserted for op=000000, funct=001100).
- Interprets the syscall service code in $v0 and argument in $a0.
- Drives the PC write enable for halt and pause, latches the LED/display value, and keeps cycle and syscall statistics for the board display.
- Sits between the control unit, the register file read ports and the PC register of the single-cycle datapath.

Parameters:
- WIDTH, 32, data width of V0, A0, LedData and the counters.
- HALT_CODE, 10, $v0 value requesting a permanent halt.
- PRINT_CODE, 34, $v0 value requesting that $a0 be latched to LedData.
- PAUSE_CODE, 50, $v0 value requesting a pause until the operator presses Go.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- IsSyscall  input  1  from the ALU decoder; the current instruction is syscall.
- V0  input  WIDTH  register file value of $2.
- A0  input  WIDTH  register file value of $4.
- Go  input  1  operator resume button, already debounced and synchronous to clk.
- PcEn  output  1  PC write enable (combinational).
- Halted  output  1  high in HALT state.
- Paused  output  1  high in PAUSE state.
- LedData  output  WIDTH  last value printed by a PRINT syscall.
- SyscallCount  output  WIDTH  number of accepted syscalls.
- CycleCount  output  WIDTH  clock cycles executed while not halted.

Behaviour:
- States: RUN, PAUSE, RESUME, HALT, encoded in 2 bits. Reset state is RUN.
- Reset values: LedData=0, SyscallCount=0, CycleCount=0, go_q=0, Halted=0, Paused=0.
- Accepted syscall (acc): IsSyscall=1 while state==RUN. Service codes are compared against the full WIDTH-bit V0 with equality.
- RUN, acc with V0==HALT_CODE: PcEn=0 in this cycle; next state HALT.
- RUN, acc with V0==PAUSE_CODE: PcEn=0 in this cycle; next state PAUSE.
- RUN, acc with V0==PRINT_CODE: LedData<=A0 at the edge; PcEn=1; stay in RUN.
- RUN, acc with any other V0: no-op; PcEn=1; stay in RUN. The syscall is still counted.
- RUN, no syscall: PcEn=1.
- PAUSE: PcEn=0; Paused=1. Stay in PAUSE until a Go rising edge (Go=1 and go_q=0); then next state RESUME.
- Go held high while entering PAUSE produces no edge; the operator must release and press again.
- RESUME: lasts exactly 1 cycle. PcEn=1 and IsSyscall is ignored (not accepted, not counted), so the PC steps past the pausing syscall. Next state RUN.
- HALT: PcEn=0; Halted=1; absorbing state. Only rst leaves it. Go is ignored.
- go_q<=Go every cycle in every state.
- SyscallCount increments by 1 at the edge of every acc cycle, all codes included.
- CycleCount increments by 1 every cycle whose current state is not HALT. The halting syscall's own cycle is counted.
- Both counters wrap modulo 2^WIDTH.
- PcEn is a pure function of state, IsSyscall and V0, with no registered delay. Halted and Paused are decoded from the state register.
- rst has priority over everything. Reset in PAUSE or HALT returns to RUN with all registers cleared. LedData is cleared by reset.

Test Plan:
- Reset, then 5 cycles with IsSyscall=0 -> PcEn=1 throughout, CycleCount=5, SyscallCount=0, LedData=0.
- IsSyscall=1, V0=34, A0=32'hDEADBEEF for 1 cycle -> PcEn=1 that cycle, LedData=32'hDEADBEEF next cycle, SyscallCount=1, state stays RUN.
- IsSyscall=1, V0=10 held -> PcEn=0 immediately, Halted=1 from next cycle, CycleCount frozen at its value +1. Pulse Go -> no change. Apply rst -> Halted=0, counters=0.
- IsSyscall=1, V0=50 held, Go held high on entry -> Paused=1, PcEn=0 indefinitely. Drop Go, then raise it -> 1 cycle later state RESUME with PcEn=1 despite IsSyscall=1, SyscallCount unchanged at 1, then RUN.
- Preload CycleCount near wrap: run 2^WIDTH-1 cycles, or use WIDTH=4 with 15 cycles -> next cycle CycleCount=0.
- Assert rst during PAUSE with LedData nonzero -> next cycle state RUN, Paused=0, PcEn=1, LedData=0.
